// File: rtl/css_mcu0_el2_ifu_iccm_repair_pkg.sv
// Shared types and elaboration helpers for the ICCM redundant-row repair unit.
package css_mcu0_el2_ifu_iccm_repair_pkg;

  localparam int ICCM_ADDR_BITS = 17;
  localparam int ICCM_DATA_W    = 39;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INSTALL = 2'd1,
    ST_WB_REQ  = 2'd2
  } rep_state_e;

  typedef struct packed {
    logic                        valid;
    logic [ICCM_ADDR_BITS-3:0]   addr;
    logic [ICCM_DATA_W-1:0]      data;
  } red_entry_t;

  function automatic int lru_idx_w(input int num_red);
    return (num_red <= 2) ? 1 : $clog2(num_red);
  endfunction

  function automatic int bank_hi(input int num_banks);
    return 1 + $clog2(num_banks);
  endfunction

endpackage

// File: rtl/css_mcu0_el2_ifu_iccm_repair_if.sv
// Correction-request and scrub write-back handshake between the IFU/array and the repair unit.
interface css_mcu0_el2_ifu_iccm_repair_if #(
  parameter int ADDR_BITS = 17,
  parameter int DATA_W    = 39
);
  logic                 correct_req;
  logic                 correct_ack;
  logic [ADDR_BITS-3:0] correct_addr;
  logic [DATA_W-1:0]    correct_data;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [ADDR_BITS-3:0] wb_addr;
  logic [DATA_W-1:0]    wb_data;

  modport master (
    output correct_req, correct_addr, correct_data, wb_ready,
    input  correct_ack, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  correct_req, correct_addr, correct_data, wb_ready,
    output correct_ack, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/css_mcu0_el2_ifu_iccm_repair_lru.sv
// True-LRU age array for the redundant rows; age 0 is most recently used.
module css_mcu0_el2_ifu_iccm_repair_lru
  import css_mcu0_el2_ifu_iccm_repair_pkg::*;
#(
  parameter int NUM_RED = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          touch_en_i,
  input  logic [lru_idx_w(NUM_RED)-1:0] touch_idx_i,
  input  logic [NUM_RED-1:0]            valid_i,
  output logic [lru_idx_w(NUM_RED)-1:0] victim_idx_o
);
  localparam int IW = lru_idx_w(NUM_RED);

  logic [IW-1:0] age_q [NUM_RED];
  logic          found;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_RED; k++) age_q[k] <= IW'(k);
    end else if (touch_en_i) begin
      for (int k = 0; k < NUM_RED; k++) begin
        if (IW'(k) == touch_idx_i) age_q[k] <= '0;
        else if (age_q[k] < age_q[touch_idx_i]) age_q[k] <= age_q[k] + 1'b1;
      end
    end
  end

  // Ages stay a permutation, so the oldest entry always carries NUM_RED-1.
  always_comb begin
    victim_idx_o = '0;
    found        = 1'b0;
    for (int k = 0; k < NUM_RED; k++) begin
      if (!valid_i[k] && !found) begin
        victim_idx_o = IW'(k);
        found        = 1'b1;
      end
    end
    if (!found) begin
      for (int k = 0; k < NUM_RED; k++) begin
        if (age_q[k] == IW'(NUM_RED - 1)) victim_idx_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/css_mcu0_el2_ifu_iccm_repair.sv
// ICCM redundant-row repair: substitutes repaired rows on reads, keeps them coherent on writes,
// and scrubs each corrected word back into the array.
//   state      | meaning
//   ST_IDLE    | accepting correction requests and flushes
//   ST_INSTALL | writing the captured word into its redundant row
//   ST_WB_REQ  | presenting the corrected word to the array until accepted
module css_mcu0_el2_ifu_iccm_repair
  import css_mcu0_el2_ifu_iccm_repair_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = ICCM_ADDR_BITS,
  parameter int NUM_RED   = 4,
  parameter int DATA_W    = ICCM_DATA_W,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_en_i,
  input  logic                        wr_en_i,
  input  logic [ADDR_BITS-1:1]        rw_addr_i,
  input  logic [2:0]                  wr_size_i,
  input  logic [2*DATA_W-1:0]         wr_data_i,
  input  logic                        correct_state_i,
  input  logic                        flush_i,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_dout_i,
  output logic [NUM_BANKS*DATA_W-1:0] bank_dout_fn_o,
  output logic [CNT_W-1:0]            install_cnt_o,
  output logic                        busy_o,
  css_mcu0_el2_ifu_iccm_repair_if.slave rep_if
);
  localparam int IW  = lru_idx_w(NUM_RED);
  localparam int BHI = bank_hi(NUM_BANKS);
  localparam int BW  = BHI - 1;

  rep_state_e state_q, state_d;
  red_entry_t ent_q [NUM_RED];
  logic [NUM_BANKS-1:0][NUM_RED-1:0] hit, hit_q;
  logic [ADDR_BITS-1:1] addr_inc;
  logic [ADDR_BITS-3:0] cap_addr_q;
  logic [DATA_W-1:0]    cap_data_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_RED-1:0]   valid_vec, hit_any_k, merge_k, wt_en, wt_hi;
  logic [IW-1:0]        rd_idx, merge_idx, victim_idx, tgt_idx, touch_idx;
  logic                 dword, ack, install, touch_en;
  logic [1:0]           unused_bits;

  assign dword       = (wr_size_i[1:0] == 2'b11);
  assign addr_inc    = rw_addr_i + (dword ? (ADDR_BITS-1)'(2) : (ADDR_BITS-1)'(1));
  assign unused_bits = {wr_size_i[2], addr_inc[1]};
  assign install     = (state_q == ST_INSTALL);

  always_comb begin
    hit       = '0;
    hit_any_k = '0;
    merge_k   = '0;
    wt_en     = '0;
    wt_hi     = '0;
    valid_vec = '0;
    for (int k = 0; k < NUM_RED; k++) begin
      valid_vec[k] = ent_q[k].valid;
      for (int i = 0; i < NUM_BANKS; i++) begin
        hit[i][k] = ent_q[k].valid &
          (((rw_addr_i[ADDR_BITS-1:2] == ent_q[k].addr) && (rw_addr_i[BHI:2] == BW'(i))) ||
           ((addr_inc[ADDR_BITS-1:2] == ent_q[k].addr) && (addr_inc[BHI:2] == BW'(i))));
        hit_any_k[k] = hit_any_k[k] | hit[i][k];
      end
      merge_k[k] = ent_q[k].valid && (ent_q[k].addr == cap_addr_q);
      wt_en[k]   = wr_en_i && ent_q[k].valid &&
                   (rw_addr_i[ADDR_BITS-1:3] == ent_q[k].addr[ADDR_BITS-3:1]) &&
                   ((rw_addr_i[2] == ent_q[k].addr[0]) || dword);
      wt_hi[k]   = ent_q[k].addr[0] && (dword || rw_addr_i[2]);
    end
  end

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    rd_idx    = '0;
    merge_idx = '0;
    for (int k = NUM_RED - 1; k >= 0; k--) begin
      if (hit_any_k[k]) rd_idx = IW'(k);
      if (merge_k[k])   merge_idx = IW'(k);
    end
    tgt_idx   = (|merge_k) ? merge_idx : victim_idx;
    touch_en  = install || (rd_en_i && correct_state_i && (|hit_any_k));
    touch_idx = install ? tgt_idx : rd_idx;
  end

  always_comb begin
    bank_dout_fn_o = bank_dout_i;
    for (int i = 0; i < NUM_BANKS; i++) begin
      for (int k = NUM_RED - 1; k >= 0; k--) begin
        if (hit_q[i][k]) bank_dout_fn_o[i*DATA_W +: DATA_W] = ent_q[k].data;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ack             = 1'b0;
    rep_if.wb_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rep_if.correct_req && !wr_en_i && !flush_i) begin
          ack     = 1'b1;
          state_d = ST_INSTALL;
        end
      end
      ST_INSTALL: state_d = ST_WB_REQ;
      ST_WB_REQ: begin
        rep_if.wb_valid = 1'b1;
        if (rep_if.wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rep_if.correct_ack = ack;
  assign rep_if.wb_addr     = cap_addr_q;
  assign rep_if.wb_data     = cap_data_q;
  assign install_cnt_o      = cnt_q;
  assign busy_o             = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hit_q      <= '0;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      for (int k = 0; k < NUM_RED; k++) ent_q[k] <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit;
      if (ack) begin
        cap_addr_q <= rep_if.correct_addr;
        cap_data_q <= rep_if.correct_data;
      end
      if (flush_i && (state_q == ST_IDLE) && !ack) begin
        for (int k = 0; k < NUM_RED; k++) ent_q[k].valid <= 1'b0;
      end
      for (int k = 0; k < NUM_RED; k++) begin
        if (wt_en[k])
          ent_q[k].data <= wt_hi[k] ? wr_data_i[2*DATA_W-1:DATA_W] : wr_data_i[DATA_W-1:0];
      end
      // Install follows write-through so a same-cycle write cannot clobber the corrected word.
      if (install) begin
        ent_q[tgt_idx].valid <= 1'b1;
        ent_q[tgt_idx].addr  <= cap_addr_q;
        ent_q[tgt_idx].data  <= cap_data_q;
        if (!(|merge_k) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  css_mcu0_el2_ifu_iccm_repair_lru #(.NUM_RED(NUM_RED)) u_lru (
    .clk          (clk),
    .rst          (rst),
    .touch_en_i   (touch_en),
    .touch_idx_i  (touch_idx),
    .valid_i      (valid_vec),
    .victim_idx_o (victim_idx)
  );

endmodule

// File: tb/tb_css_mcu0_el2_ifu_iccm_repair.sv
// Directed bench for the ICCM repair unit: reset, install, LRU, merge, write-through, flush, stall.
module tb_css_mcu0_el2_ifu_iccm_repair;
  localparam int NB = 4;
  localparam int AB = 17;
  localparam int NR = 4;
  localparam int DW = 39;
  localparam int CW = 8;
  localparam logic [DW-1:0] RAW = 39'hAA;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rd_en, wr_en, correct_state, flush;
  logic [AB-1:1]      rw_addr;
  logic [2:0]         wr_size;
  logic [2*DW-1:0]    wr_data;
  logic [NB*DW-1:0]   bank_dout, bank_dout_fn;
  logic [CW-1:0]      install_cnt;
  logic               busy;

  int tests_run    = 0;
  int tests_failed = 0;

  css_mcu0_el2_ifu_iccm_repair_if #(.ADDR_BITS(AB), .DATA_W(DW)) rif ();

  css_mcu0_el2_ifu_iccm_repair #(
    .NUM_BANKS(NB), .ADDR_BITS(AB), .NUM_RED(NR), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_en_i         (rd_en),
    .wr_en_i         (wr_en),
    .rw_addr_i       (rw_addr),
    .wr_size_i       (wr_size),
    .wr_data_i       (wr_data),
    .correct_state_i (correct_state),
    .flush_i         (flush),
    .bank_dout_i     (bank_dout),
    .bank_dout_fn_o  (bank_dout_fn),
    .install_cnt_o   (install_cnt),
    .busy_o          (busy),
    .rep_if          (rif)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fn(input int b);
    return bank_dout_fn[b*DW +: DW];
  endfunction

  task automatic drive_idle();
    rd_en = 0; wr_en = 0; correct_state = 0; flush = 0;
    rw_addr = '0; wr_size = 3'b000; wr_data = '0;
    bank_dout = {NB{RAW}};
    rif.correct_req = 0; rif.correct_addr = '0; rif.correct_data = '0; rif.wb_ready = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic do_install(input logic [AB-3:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rif.correct_req = 1; rif.correct_addr = a; rif.correct_data = d; rif.wb_ready = 1;
    @(negedge clk);
    rif.correct_req = 0;
    @(negedge clk);
    @(negedge clk);
    rif.wb_ready = 0;
  endtask

  task automatic do_read(input logic [AB-1:1] hw, input logic cs);
    @(negedge clk);
    rd_en = 1; rw_addr = hw; correct_state = cs; wr_size = 3'b000;
    @(negedge clk);
    rd_en = 0; correct_state = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    do_read(16'h40, 0);
    for (int b = 0; b < NB; b++) begin
      tests_run++;
      if (fn(b) !== RAW) begin
        tests_failed++; $display("FAIL reset_read bank%0d: got %h want %h", b, fn(b), RAW);
      end
    end
    tests_run++;
    if (rif.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid: got %b want 0", rif.wb_valid); end
    tests_run++;
    if (install_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_install_cnt: got %0d want 0", install_cnt); end
    tests_run++;
    if (busy !== 1'b0 || rif.correct_ack !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy_ack: got %b%b want 00", busy, rif.correct_ack);
    end
  endtask

  task automatic test_install();
    @(negedge clk);
    rif.correct_req = 1; rif.correct_addr = 15'h10; rif.correct_data = 39'h1234; rif.wb_ready = 1;
    #1;
    tests_run++;
    if (rif.correct_ack !== 1'b1) begin tests_failed++; $display("FAIL install_ack_c0: got %b want 1", rif.correct_ack); end
    @(negedge clk);
    rif.correct_req = 0;
    #1;
    tests_run++;
    if (busy !== 1'b1 || rif.wb_valid !== 1'b0) begin
      tests_failed++; $display("FAIL install_c1 busy/wb_valid: got %b%b want 10", busy, rif.wb_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rif.wb_valid !== 1'b1 || rif.wb_addr !== 15'h10 || rif.wb_data !== 39'h1234) begin
      tests_failed++;
      $display("FAIL install_wb_c2: got v=%b a=%h d=%h want v=1 a=10 d=1234", rif.wb_valid, rif.wb_addr, rif.wb_data);
    end
    @(negedge clk);
    rif.wb_ready = 0;
    #1;
    tests_run++;
    if (rif.wb_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL install_done_c3: got wb_valid=%b busy=%b want 0 0", rif.wb_valid, busy);
    end
    do_read(16'h20, 0);
    tests_run++;
    if (fn(0) !== 39'h1234) begin tests_failed++; $display("FAIL install_read bank0: got %h want 1234", fn(0)); end
    tests_run++;
    if (fn(1) !== RAW) begin tests_failed++; $display("FAIL install_read bank1: got %h want %h", fn(1), RAW); end
    tests_run++;
    if (install_cnt !== 8'd1) begin tests_failed++; $display("FAIL install_cnt: got %0d want 1", install_cnt); end
  endtask

  task automatic test_lru();
    reset_dut();
    do_install(15'h20, 39'h1111);
    do_install(15'h24, 39'h2222);
    do_install(15'h28, 39'h3333);
    do_install(15'h2C, 39'h4444);
    do_read(16'h40, 1);
    do_read(16'h50, 1);
    do_install(15'h30, 39'h5E5E);
    tests_run++;
    if (install_cnt !== 8'd5) begin tests_failed++; $display("FAIL lru_install_cnt: got %0d want 5", install_cnt); end
    do_read(16'h60, 0);
    tests_run++;
    if (fn(0) !== 39'h5E5E) begin tests_failed++; $display("FAIL lru_new_entry: got %h want 5e5e", fn(0)); end
    do_read(16'h48, 0);
    tests_run++;
    if (fn(0) !== RAW) begin tests_failed++; $display("FAIL lru_evicted_entry1: got %h want %h", fn(0), RAW); end
    do_read(16'h40, 0);
    tests_run++;
    if (fn(0) !== 39'h1111) begin tests_failed++; $display("FAIL lru_kept_entry0: got %h want 1111", fn(0)); end
    do_read(16'h50, 0);
    tests_run++;
    if (fn(0) !== 39'h3333) begin tests_failed++; $display("FAIL lru_kept_entry2: got %h want 3333", fn(0)); end
  endtask

  task automatic test_merge();
    do_install(15'h20, 39'h55);
    tests_run++;
    if (install_cnt !== 8'd5) begin tests_failed++; $display("FAIL merge_install_cnt: got %0d want 5", install_cnt); end
    do_read(16'h40, 0);
    tests_run++;
    if (fn(0) !== 39'h55) begin tests_failed++; $display("FAIL merge_read: got %h want 55", fn(0)); end
    do_read(16'h58, 0);
    tests_run++;
    if (fn(0) !== 39'h4444) begin tests_failed++; $display("FAIL merge_no_evict: got %h want 4444", fn(0)); end
    do_read(16'h60, 0);
    tests_run++;
    if (fn(0) !== 39'h5E5E) begin tests_failed++; $display("FAIL merge_other_entry: got %h want 5e5e", fn(0)); end
  endtask

  task automatic test_write_through();
    reset_dut();
    do_install(15'h10, 39'h1);
    do_install(15'h11, 39'h2);
    @(negedge clk);
    wr_en = 1; rd_en = 1; rw_addr = 16'h20; wr_size = 3'b011; wr_data = {39'hBEEF, 39'hCAFE};
    @(negedge clk);
    wr_en = 0; rd_en = 0;
    #1;
    tests_run++;
    if (fn(0) !== 39'hCAFE) begin tests_failed++; $display("FAIL wt_dword_lo: got %h want cafe", fn(0)); end
    tests_run++;
    if (fn(1) !== 39'hBEEF) begin tests_failed++; $display("FAIL wt_dword_hi: got %h want beef", fn(1)); end
    @(negedge clk);
    wr_en = 1; rw_addr = 16'h22; wr_size = 3'b010; wr_data = {39'h7777, 39'h6666};
    @(negedge clk);
    wr_en = 0;
    do_read(16'h21, 0);
    tests_run++;
    if (fn(0) !== 39'hCAFE) begin tests_failed++; $display("FAIL wt_word_other: got %h want cafe", fn(0)); end
    tests_run++;
    if (fn(1) !== 39'h7777) begin tests_failed++; $display("FAIL wt_word_odd: got %h want 7777", fn(1)); end
  endtask

  task automatic test_flush();
    reset_dut();
    do_install(15'h8, 39'h99);
    @(negedge clk);
    flush = 1; rif.correct_req = 1; rif.correct_addr = 15'h9; rif.correct_data = 39'h9;
    #1;
    tests_run++;
    if (rif.correct_ack !== 1'b0) begin tests_failed++; $display("FAIL flush_blocks_ack: got %b want 0", rif.correct_ack); end
    @(negedge clk);
    flush = 0; rif.correct_req = 0;
    do_read(16'h10, 0);
    tests_run++;
    if (fn(0) !== RAW || busy !== 1'b0) begin
      tests_failed++; $display("FAIL flush_idle: got %h busy=%b want %h busy=0", fn(0), busy, RAW);
    end
    @(negedge clk);
    rif.correct_req = 1; rif.correct_addr = 15'hC; rif.correct_data = 39'hCC; rif.wb_ready = 0;
    @(negedge clk);
    rif.correct_req = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    rd_en = 1; rw_addr = 16'h18;
    @(negedge clk);
    #1;
    tests_run++;
    if (fn(0) !== 39'hCC || busy !== 1'b1) begin
      tests_failed++; $display("FAIL flush_held_off: got %h busy=%b want cc busy=1", fn(0), busy);
    end
    rif.wb_ready = 1; rd_en = 0;
    @(negedge clk);
    #1;
    tests_run++;
    if (rif.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_wb_done: got %b want 0", rif.wb_valid); end
    @(negedge clk);
    flush = 0; rif.wb_ready = 0;
    do_read(16'h18, 0);
    tests_run++;
    if (fn(0) !== RAW) begin tests_failed++; $display("FAIL flush_after_idle: got %h want %h", fn(0), RAW); end
  endtask

  task automatic test_stall_reset();
    reset_dut();
    @(negedge clk);
    rif.correct_req = 1; rif.correct_addr = 15'h33; rif.correct_data = 39'h777; rif.wb_ready = 0;
    #1;
    tests_run++;
    if (rif.correct_ack !== 1'b1) begin tests_failed++; $display("FAIL stall_ack_c0: got %b want 1", rif.correct_ack); end
    @(negedge clk);
    rif.correct_req = 0;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      rif.correct_req = (j % 2 == 0); rif.correct_addr = 15'h1; rif.correct_data = 39'h1;
      rd_en = 1; rw_addr = 16'h66;
      #1;
      tests_run++;
      if (rif.correct_ack !== 1'b0 || rif.wb_valid !== 1'b1 || rif.wb_addr !== 15'h33 || rif.wb_data !== 39'h777) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got ack=%b v=%b a=%h d=%h want 0 1 33 777",
                 j, rif.correct_ack, rif.wb_valid, rif.wb_addr, rif.wb_data);
      end
    end
    @(negedge clk);
    rif.correct_req = 0;
    #1;
    tests_run++;
    if (fn(3) !== 39'h777) begin tests_failed++; $display("FAIL stall_read bank3: got %h want 777", fn(3)); end
    rst = 1;
    @(negedge clk);
    #1;
    tests_run++;
    if (rif.wb_valid !== 1'b0 || busy !== 1'b0 || install_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_wb: got v=%b busy=%b cnt=%0d want 0 0 0", rif.wb_valid, busy, install_cnt);
    end
    rst = 0; rd_en = 0;
    do_read(16'h66, 0);
    tests_run++;
    if (fn(3) !== RAW) begin tests_failed++; $display("FAIL reset_valid_cleared: got %h want %h", fn(3), RAW); end
  endtask

  task automatic test_saturate();
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      do_install(15'(i), 39'(i));
      if (i == 254) begin
        tests_run++;
        if (install_cnt !== 8'd255) begin tests_failed++; $display("FAIL cnt_at_255: got %0d want 255", install_cnt); end
      end
    end
    tests_run++;
    if (install_cnt !== 8'd255) begin tests_failed++; $display("FAIL cnt_saturated: got %0d want 255", install_cnt); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_install();
    test_lru();
    test_merge();
    test_write_through();
    test_flush();
    test_stall_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
